capture_readout_tx: RTL

Read side of the DataCapture sample buffer. Drains captured 16-bit words through the dataRead/dataValid handshake and serialises them as a framed byte stream toward the host byte link (FT245/UART transmitter).
- Frame format: header byte, each word as two bytes, 16-bit word-count trailer.
- Drives readyToTransmit back to DataCapture so capture data is only offered while the link side can accept a frame.

---
 rtl/capture_readout_tx_if.sv | 26 ++
 rtl/capture_readout_tx.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/capture_readout_tx_if.sv
// Capture-buffer read handshake plus host byte-link signals for capture_readout_tx.
// master = readout block, slave = DataCapture/host-link side.
interface capture_readout_tx_if;
    localparam int unsigned WORD_W = 16;
    localparam int unsigned BYTE_W = 8;

    logic              dataReadyToRead;
    logic              dataValid;
    logic              dataEmpty;
    logic [WORD_W-1:0] dataIn;
    logic              dataRead;
    logic              readyToTransmit;
    logic [BYTE_W-1:0] txData;
    logic              txStrobe;
    logic              txReady;

    modport master (
        input  dataReadyToRead, dataValid, dataEmpty, dataIn, txReady,
        output dataRead, readyToTransmit, txData, txStrobe
    );

    modport slave (
        output dataReadyToRead, dataValid, dataEmpty, dataIn, txReady,
        input  dataRead, readyToTransmit, txData, txStrobe
    );
endinterface

// File: rtl/capture_readout_tx.sv
// Drains DataCapture words and sends them as a framed byte stream: header, word bytes, 16-bit count trailer.
// Optional trailing XOR checksum byte when CAPTURE_READOUT_CHECKSUM_EN is defined.
module capture_readout_tx #(
    parameter int unsigned MAX_WORDS     = 512,
    parameter logic [7:0]  HEADER        = 8'hA5,
    parameter bit          MSB_FIRST     = 1'b1,
    parameter int unsigned VALID_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    capture_readout_tx_if.master bus,
    output logic                 busy,
    output logic                 frameDone,
    output logic                 timeoutErr
);
    localparam int unsigned CNT_W = 16;
    localparam int unsigned TMR_W = $clog2(VALID_TIMEOUT + 1);

`ifdef CAPTURE_READOUT_CHECKSUM_EN
    typedef enum logic [3:0] {
        ST_IDLE, ST_HDR, ST_REQ, ST_WAIT_VALID, ST_SEND_A, ST_SEND_B,
        ST_TRAIL_HI, ST_TRAIL_LO, ST_CHK
    } state_t;
`else
    typedef enum logic [3:0] {
        ST_IDLE, ST_HDR, ST_REQ, ST_WAIT_VALID, ST_SEND_A, ST_SEND_B,
        ST_TRAIL_HI, ST_TRAIL_LO
    } state_t;
`endif

    state_t             state, stateNext;
    logic [CNT_W-1:0]   wordCount, countNext;
    logic [15:0]        word, wordNext;
    logic [TMR_W-1:0]   tmr, tmrNext;
    logic               accept;
    logic               toErrNext, doneNext, readNext, strobeNext, rttNext, busyNext;
    logic [7:0]         byteNext;
`ifdef CAPTURE_READOUT_CHECKSUM_EN
    logic [7:0]         csum, csumNext;
`endif

    // State and registered outputs; outputs are precomputed from the state being entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state               <= ST_IDLE;
            wordCount           <= '0;
            word                <= '0;
            tmr                 <= '0;
            timeoutErr          <= 1'b0;
            frameDone           <= 1'b0;
            busy                <= 1'b0;
            bus.dataRead        <= 1'b0;
            bus.readyToTransmit <= 1'b0;
            bus.txStrobe        <= 1'b0;
            bus.txData          <= '0;
`ifdef CAPTURE_READOUT_CHECKSUM_EN
            csum                <= '0;
`endif
        end else begin
            state               <= stateNext;
            wordCount           <= countNext;
            word                <= wordNext;
            tmr                 <= tmrNext;
            timeoutErr          <= toErrNext;
            frameDone           <= doneNext;
            busy                <= busyNext;
            bus.dataRead        <= readNext;
            bus.readyToTransmit <= rttNext;
            bus.txStrobe        <= strobeNext;
            bus.txData          <= byteNext;
`ifdef CAPTURE_READOUT_CHECKSUM_EN
            csum                <= csumNext;
`endif
        end
    end

    always_comb begin
        stateNext = state;
        countNext = wordCount;
        wordNext  = word;
        tmrNext   = tmr;
        toErrNext = timeoutErr;
        doneNext  = 1'b0;
        readNext  = 1'b0;
        accept    = bus.txStrobe && bus.txReady;
`ifdef CAPTURE_READOUT_CHECKSUM_EN
        csumNext  = csum;
        if (state == ST_IDLE)
            csumNext = '0;
        else if (accept)
            csumNext = csum ^ bus.txData;
`endif

        case (state)
            ST_IDLE: if (bus.dataReadyToRead) begin
                stateNext = ST_HDR;
                countNext = '0;
                toErrNext = 1'b0;
            end
            ST_HDR: if (accept) stateNext = ST_REQ;
            ST_REQ: begin
                if (bus.dataEmpty || wordCount == CNT_W'(MAX_WORDS)) begin
                    stateNext = ST_TRAIL_HI;
                end else begin
                    stateNext = ST_WAIT_VALID;
                    readNext  = 1'b1;
                    tmrNext   = '0;
                end
            end
            ST_WAIT_VALID: begin
                if (bus.dataValid) begin
                    wordNext  = bus.dataIn;
                    if (wordCount != CNT_W'(MAX_WORDS))
                        countNext = wordCount + CNT_W'(1);
                    stateNext = ST_SEND_A;
                end else if (tmr == TMR_W'(VALID_TIMEOUT - 1)) begin
                    toErrNext = 1'b1;
                    stateNext = ST_TRAIL_HI;
                end else begin
                    tmrNext = tmr + TMR_W'(1);
                end
            end
            ST_SEND_A:   if (accept) stateNext = ST_SEND_B;
            ST_SEND_B:   if (accept) stateNext = ST_REQ;
            ST_TRAIL_HI: if (accept) stateNext = ST_TRAIL_LO;
`ifdef CAPTURE_READOUT_CHECKSUM_EN
            ST_TRAIL_LO: if (accept) stateNext = ST_CHK;
            ST_CHK: if (accept) begin
                stateNext = ST_IDLE;
                doneNext  = 1'b1;
            end
`else
            ST_TRAIL_LO: if (accept) begin
                stateNext = ST_IDLE;
                doneNext  = 1'b1;
            end
`endif
            default: stateNext = ST_IDLE;
        endcase

        // Byte for the state being entered; stays constant while the link stalls.
        strobeNext = 1'b1;
        byteNext   = '0;
        case (stateNext)
            ST_HDR:      byteNext = HEADER;
            ST_SEND_A:   byteNext = MSB_FIRST ? wordNext[15:8] : wordNext[7:0];
            ST_SEND_B:   byteNext = MSB_FIRST ? wordNext[7:0]  : wordNext[15:8];
            ST_TRAIL_HI: byteNext = countNext[15:8];
            ST_TRAIL_LO: byteNext = countNext[7:0];
`ifdef CAPTURE_READOUT_CHECKSUM_EN
            ST_CHK:      byteNext = csumNext;
`endif
            default:     strobeNext = 1'b0;
        endcase

        rttNext  = stateNext inside {ST_IDLE, ST_REQ, ST_WAIT_VALID, ST_SEND_A, ST_SEND_B};
        busyNext = stateNext != ST_IDLE;
    end
endmodule
